alu_op: RTL and testbench
=========================

// Module: alu_op
// PURPOSE
//  Main-decoder -> ALU-control bridge in the RV32I core decode stage.
//  - Takes the one-hot instruction-class flags from the type decoder.
//  - Produces the 3-bit ALU operation class consumed by the ALU-control block.
//  - Registers the result once per clock; flags simultaneous class assertion.
// PARAMETERS
//  none (encoding width fixed at 3 bits)
// PORTS
//  clk_i        in   1  clock, rising edge
//  rst_i        in   1  reset, asynchronous, active-high
//  r_type_i     in   1  R-type (OP) instruction
//  i_type_i     in   1  I-type ALU (OP-IMM) instruction
//  store_i      in   1  S-type store
//  load_i       in   1  load
//  branch_i     in   1  SB-type conditional branch
//  jal_i        in   1  JAL
//  jalr_i       in   1  JALR
//  lui_i        in   1  LUI
//  aluop_o      out  3  ALU operation class (registered)
//  multi_hot_o  out  1  >1 class flag asserted in the sampled cycle (registered)
// BEHAVIOUR
//  - Interface: one clock (clk_i); reset rst_i is asynchronous, active-high.
//  - Encoding (next-state value, combinational from inputs):
//    r_type 000 | i_type 001 | branch 010 | jal 011 | jalr 011
//    load 100 | store 101 | lui 110 | no flag set 111 (default/NOP)
//  - Latency: exactly 1 cycle; aluop_o/multi_hot_o update on each rising
//    clk_i edge from inputs sampled at that edge. No enable, no handshake.
//  - Reset: while rst_i=1, aluop_o=3'b111, multi_hot_o=0, immediately
//    (async assert); first update on the first rising edge after rst_i=0.
//  - Multi-hot inputs: fixed priority r_type > load > store > branch >
//    i_type > jalr > jal > lui; highest-priority set flag selects the code.
//    multi_hot_o=1 for that cycle whenever popcount(flags) >= 2.
//  - jal+jalr together: code 011, multi_hot_o=1.
//  - All-zero inputs: aluop_o=111, multi_hot_o=0.
//  - Reset asserted mid-stream overrides any pending sample; no state
//    besides the two output registers.
//  - X/Z on inputs is not handled; inputs are defined whenever rst_i=0.
// STRUCTURE
//  - Shared package (core decode pkg): localparam logic [2:0]
//    ALUOP_R=3'b000, ALUOP_I=3'b001, ALUOP_BR=3'b010, ALUOP_JUMP=3'b011,
//    ALUOP_LOAD=3'b100, ALUOP_STORE=3'b101, ALUOP_LUI=3'b110,
//    ALUOP_DEFAULT=3'b111; used by ALU-control and this block.
//  - Single module: combinational priority encoder (always_comb, unique0-free
//    if/else chain) + popcount compare + one always_ff with async reset.
//  - No sub-module; encoder may be a package function alu_op_encode().
// TESTING
//  - Reset: rst_i=1 with r_type_i=1 -> aluop_o=111, multi_hot_o=0 before and
//    after clock edges; release -> next edge aluop_o=000.
//  - Single-hot sweep, one class per cycle r,i,store,load,branch,jal,jalr,lui
//    -> aluop_o 000,001,101,100,010,011,011,110 one cycle later, multi_hot_o=0.
//  - All flags 0 -> aluop_o=111, multi_hot_o=0.
//  - r_type_i=1, load_i=1 -> aluop_o=000, multi_hot_o=1; store_i=1, lui_i=1
//    -> 101, multi_hot_o=1.
//  - Latency check: change inputs mid-cycle -> aluop_o unchanged until next
//    rising edge.
//  - Async reset mid-sequence (rst_i pulsed between edges while lui_i=1)
//    -> aluop_o drops to 111 without a clock edge; returns 110 after release+edge.

Source files
------------

// File: rtl/alu_op_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_pkg
// Description : Core decode package shared by the ALU-op bridge and ALU
//               control: ALU operation class codes plus the priority encoder
//               and flag-count helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_op_pkg;

    localparam logic [2:0] ALUOP_R       = 3'b000;
    localparam logic [2:0] ALUOP_I       = 3'b001;
    localparam logic [2:0] ALUOP_BR      = 3'b010;
    localparam logic [2:0] ALUOP_JUMP    = 3'b011;
    localparam logic [2:0] ALUOP_LOAD    = 3'b100;
    localparam logic [2:0] ALUOP_STORE   = 3'b101;
    localparam logic [2:0] ALUOP_LUI     = 3'b110;
    localparam logic [2:0] ALUOP_DEFAULT = 3'b111;

    localparam int unsigned C_NUM_CLASSES = 8;

    // Field order is the resolution priority, highest first.
    typedef struct packed {
        logic r_type;
        logic load;
        logic store;
        logic branch;
        logic i_type;
        logic jalr;
        logic jal;
        logic lui;
    } class_flags_t;

    function automatic logic [2:0] alu_op_encode(input class_flags_t flags);
        logic [2:0] code;
        code = ALUOP_DEFAULT;
        if (flags.r_type)      code = ALUOP_R;
        else if (flags.load)   code = ALUOP_LOAD;
        else if (flags.store)  code = ALUOP_STORE;
        else if (flags.branch) code = ALUOP_BR;
        else if (flags.i_type) code = ALUOP_I;
        else if (flags.jalr)   code = ALUOP_JUMP;
        else if (flags.jal)    code = ALUOP_JUMP;
        else if (flags.lui)    code = ALUOP_LUI;
        return code;
    endfunction

    function automatic logic [3:0] flag_count(input class_flags_t flags);
        logic [3:0] cnt;
        logic [C_NUM_CLASSES-1:0] bits;
        bits = flags;
        cnt  = 4'd0;
        for (int k = 0; k < C_NUM_CLASSES; k++) begin
            cnt = cnt + {3'b000, bits[k]};
        end
        return cnt;
    endfunction

endpackage : alu_op_pkg
`default_nettype wire

// File: rtl/alu_op.sv
`default_nettype none
// ============================================================================
// Module      : alu_op
// Description : Main-decoder to ALU-control bridge. Priority-encodes the
//               instruction-class flags into a 3-bit ALU op class and flags
//               simultaneous class assertion; both outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op
    import alu_op_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       r_type_i,
    input  logic       i_type_i,
    input  logic       store_i,
    input  logic       load_i,
    input  logic       branch_i,
    input  logic       jal_i,
    input  logic       jalr_i,
    input  logic       lui_i,
    output logic [2:0] aluop_o,
    output logic       multi_hot_o
);

    class_flags_t w_flags;
    logic [2:0]   w_aluop_next;
    logic         w_multi_hot_next;
    logic [2:0]   r_aluop;
    logic         r_multi_hot;

    always_comb begin
        w_flags        = '0;
        w_flags.r_type = r_type_i;
        w_flags.load   = load_i;
        w_flags.store  = store_i;
        w_flags.branch = branch_i;
        w_flags.i_type = i_type_i;
        w_flags.jalr   = jalr_i;
        w_flags.jal    = jal_i;
        w_flags.lui    = lui_i;
    end

    always_comb begin
        w_aluop_next     = alu_op_encode(w_flags);
        w_multi_hot_next = (flag_count(w_flags) >= 4'd2);
    end

    // Reset parks the output on the NOP code so ALU control sees no class.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_aluop     <= ALUOP_DEFAULT;
            r_multi_hot <= 1'b0;
        end else begin
            r_aluop     <= w_aluop_next;
            r_multi_hot <= w_multi_hot_next;
        end
    end

    assign aluop_o     = r_aluop;
    assign multi_hot_o = r_multi_hot;

endmodule : alu_op
`default_nettype wire

// File: tb/tb_alu_op.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op
// Description : Directed self-checking bench for alu_op.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       r_type_i = 1'b0;
    logic       i_type_i = 1'b0;
    logic       store_i = 1'b0;
    logic       load_i = 1'b0;
    logic       branch_i = 1'b0;
    logic       jal_i = 1'b0;
    logic       jalr_i = 1'b0;
    logic       lui_i = 1'b0;
    logic [2:0] aluop_o;
    logic       multi_hot_o;

    int checks = 0;
    int errors = 0;

    alu_op dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .r_type_i    (r_type_i),
        .i_type_i    (i_type_i),
        .store_i     (store_i),
        .load_i      (load_i),
        .branch_i    (branch_i),
        .jal_i       (jal_i),
        .jalr_i      (jalr_i),
        .lui_i       (lui_i),
        .aluop_o     (aluop_o),
        .multi_hot_o (multi_hot_o)
    );

    always #5 clk_i = ~clk_i;

    // Vector order: {r_type, i_type, store, load, branch, jal, jalr, lui}
    task automatic set_flags(input logic [7:0] v);
        {r_type_i, i_type_i, store_i, load_i, branch_i, jal_i, jalr_i, lui_i} = v;
    endtask

    task automatic check(input string tag, input logic [2:0] exp_op, input logic exp_mh);
        checks++;
        assert (aluop_o === exp_op) else begin
            errors++;
            $display("FAIL %s aluop: observed %b expected %b", tag, aluop_o, exp_op);
            $error("%s aluop observed %b expected %b", tag, aluop_o, exp_op);
        end
        checks++;
        assert (multi_hot_o === exp_mh) else begin
            errors++;
            $display("FAIL %s multi_hot: observed %b expected %b", tag, multi_hot_o, exp_mh);
            $error("%s multi_hot observed %b expected %b", tag, multi_hot_o, exp_mh);
        end
    endtask

    // Drive between edges, then sample 1 time unit after the capturing edge.
    task automatic step(input string tag, input logic [7:0] v,
                        input logic [2:0] exp_op, input logic exp_mh);
        @(negedge clk_i);
        set_flags(v);
        @(posedge clk_i);
        #1;
        check(tag, exp_op, exp_mh);
    endtask

    initial begin
        // Reset held with r_type asserted
        #1;
        rst_i = 1'b1;
        set_flags(8'b1000_0000);
        #1;
        check("reset_async", 3'b111, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_held", 3'b111, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("reset_release_noedge", 3'b111, 1'b0);
        @(posedge clk_i);
        #1;
        check("reset_first_edge", 3'b000, 1'b0);

        // Single-hot sweep
        step("r_type", 8'b1000_0000, 3'b000, 1'b0);
        step("i_type", 8'b0100_0000, 3'b001, 1'b0);
        step("store",  8'b0010_0000, 3'b101, 1'b0);
        step("load",   8'b0001_0000, 3'b100, 1'b0);
        step("branch", 8'b0000_1000, 3'b010, 1'b0);
        step("jal",    8'b0000_0100, 3'b011, 1'b0);
        step("jalr",   8'b0000_0010, 3'b011, 1'b0);
        step("lui",    8'b0000_0001, 3'b110, 1'b0);
        step("none",   8'b0000_0000, 3'b111, 1'b0);

        // Multi-hot priority
        step("r_load",      8'b1001_0000, 3'b000, 1'b1);
        step("store_lui",   8'b0010_0001, 3'b101, 1'b1);
        step("jal_jalr",    8'b0000_0110, 3'b011, 1'b1);
        step("all_ones",    8'b1111_1111, 3'b000, 1'b1);
        step("load_br_i",   8'b0101_1000, 3'b100, 1'b1);
        step("branch_i",    8'b0100_1000, 3'b010, 1'b1);
        step("i_jalr",      8'b0100_0010, 3'b001, 1'b1);
        step("jalr_lui",    8'b0000_0011, 3'b011, 1'b1);
        step("store_br",    8'b0010_1000, 3'b101, 1'b1);
        step("none_again",  8'b0000_0000, 3'b111, 1'b0);

        // Latency: mid-cycle input change must not show before the next edge
        step("lat_lui", 8'b0000_0001, 3'b110, 1'b0);
        @(negedge clk_i);
        set_flags(8'b1001_0000);
        #2;
        check("lat_hold", 3'b110, 1'b0);
        @(posedge clk_i);
        #1;
        check("lat_update", 3'b000, 1'b1);

        // Asynchronous reset pulse between edges while lui is asserted
        step("ar_lui", 8'b0000_0001, 3'b110, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("ar_assert", 3'b111, 1'b0);
        #1;
        rst_i = 1'b0;
        #1;
        check("ar_release_noedge", 3'b111, 1'b0);
        @(posedge clk_i);
        #1;
        check("ar_recover", 3'b110, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alu_op
`default_nettype wire
